// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic light sequencer.
package traffic_pkg;

  typedef enum logic [1:0] {
    LIGHT_OFF    = 2'd0,
    LIGHT_GREEN  = 2'd1,
    LIGHT_YELLOW = 2'd2,
    LIGHT_RED    = 2'd3
  } light_phase_t;

  // Width of every duration counter and length value.
  localparam int unsigned DUR_W = 28;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // One right-shifting Galois step.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] shifted;
    shifted = v >> 1;
    return v[0] ? (shifted ^ LFSR_MASK) : shifted;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; a zero seed would lock up, so it becomes 1.
module lfsr16
  import traffic_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] seed_fix;
  logic [15:0] q_q;

  assign seed_fix = (seed == 16'h0000) ? 16'h0001 : seed;

  // Advance every cycle; reload the (fixed-up) seed on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= seed_fix;
    end else begin
      q_q <= lfsr_step(q_q);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/traffic_light.sv
// Red/yellow/green sequencer for Red Light, Green Light. Durations are
// randomised from an LFSR, green shortens with the round, and the enforced
// red_light only asserts after a grace window inside the red phase.
module traffic_light
  import traffic_pkg::*;
#(
  parameter logic [DUR_W-1:0] GREEN_MIN  = 28'd75_000_000,
  parameter logic [DUR_W-1:0] GREEN_STEP = 28'd6_250_000,
  parameter logic [DUR_W-1:0] YELLOW_LEN = 28'd25_000_000,
  parameter logic [DUR_W-1:0] RED_MIN    = 28'd50_000_000,
  parameter logic [DUR_W-1:0] RED_STEP   = 28'd6_250_000,
  parameter logic [DUR_W-1:0] ROUND_TRIM = 28'd12_500_000,
  parameter logic [DUR_W-1:0] GRACE_LEN  = 28'd5_000_000,
  parameter logic             RAND_EN    = 1'b1,
  parameter logic [15:0]      LFSR_SEED  = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       game_active,
  input  logic [1:0] round_num,
  output logic       red_light,
  output logic       red_lamp,
  output logic       yellow_lamp,
  output logic       green_lamp,
  output logic [1:0] phase,
  output logic       phase_change
);

  // Extra headroom so the length arithmetic can be saturated instead of wrapping.
  localparam int unsigned CW = DUR_W + 6;

  // Green never shrinks below half its minimum, and never to zero cycles.
  localparam logic [DUR_W-1:0] GREEN_FLOOR =
      (GREEN_MIN >= DUR_W'(2)) ? (GREEN_MIN >> 1) : DUR_W'(1);

  light_phase_t     phase_q, phase_d;
  logic [DUR_W-1:0] phase_cnt_q, phase_cnt_d;
  logic [DUR_W-1:0] grace_cnt_q, grace_cnt_d;
  logic             phase_change_q;

  logic [15:0]      lfsr_q;
  logic [3:0]       rnd;
  logic [1:0]       round_eff;
  logic [CW-1:0]    green_base, green_trim, red_full;
  logic [DUR_W-1:0] green_len, red_len;
  logic             unused_lfsr;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  // Only the low nibble feeds the random term.
  assign unused_lfsr = ^lfsr_q[15:4];
  assign rnd         = RAND_EN ? lfsr_q[3:0] : 4'd0;
  assign round_eff   = (round_num == 2'd0) ? 2'd1 : round_num;

  function automatic logic [DUR_W-1:0] sat_dur(input logic [CW-1:0] v);
    if (v > CW'({DUR_W{1'b1}})) begin
      return {DUR_W{1'b1}};
    end
    return v[DUR_W-1:0];
  endfunction

  // Phase lengths for the current random value and round, used at phase entry.
  always_comb begin
    green_base = CW'(GREEN_MIN) + CW'(rnd) * CW'(GREEN_STEP);
    green_trim = (CW'(round_eff) - CW'(1)) * CW'(ROUND_TRIM);
    red_full   = CW'(RED_MIN) + CW'(rnd) * CW'(RED_STEP);
    if (green_base < green_trim + CW'(GREEN_FLOOR)) begin
      green_len = GREEN_FLOOR;
    end else begin
      green_len = sat_dur(green_base - green_trim);
    end
    red_len = sat_dur(red_full);
  end

  // Next phase and counter values; dropping game_active overrides everything.
  always_comb begin
    phase_d     = phase_q;
    phase_cnt_d = phase_cnt_q;
    grace_cnt_d = grace_cnt_q;
    if (!game_active) begin
      phase_d     = LIGHT_OFF;
      phase_cnt_d = '0;
      grace_cnt_d = '0;
    end else begin
      unique case (phase_q)
        LIGHT_OFF: begin
          phase_d     = LIGHT_GREEN;
          phase_cnt_d = green_len - DUR_W'(1);
        end
        LIGHT_GREEN: begin
          if (phase_cnt_q == '0) begin
            phase_d     = LIGHT_YELLOW;
            phase_cnt_d = YELLOW_LEN - DUR_W'(1);
          end else begin
            phase_cnt_d = phase_cnt_q - DUR_W'(1);
          end
        end
        LIGHT_YELLOW: begin
          if (phase_cnt_q == '0) begin
            phase_d     = LIGHT_RED;
            phase_cnt_d = red_len - DUR_W'(1);
            grace_cnt_d = '0;
          end else begin
            phase_cnt_d = phase_cnt_q - DUR_W'(1);
          end
        end
        LIGHT_RED: begin
          if (grace_cnt_q < GRACE_LEN) begin
            grace_cnt_d = grace_cnt_q + DUR_W'(1);
          end
          if (phase_cnt_q == '0) begin
            phase_d     = LIGHT_GREEN;
            phase_cnt_d = green_len - DUR_W'(1);
            grace_cnt_d = '0;
          end else begin
            phase_cnt_d = phase_cnt_q - DUR_W'(1);
          end
        end
        default: begin
          phase_d     = LIGHT_OFF;
          phase_cnt_d = '0;
          grace_cnt_d = '0;
        end
      endcase
    end
  end

  // Phase, counters and the registered phase-entry pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q        <= LIGHT_OFF;
      phase_cnt_q    <= '0;
      grace_cnt_q    <= '0;
      phase_change_q <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      phase_cnt_q    <= phase_cnt_d;
      grace_cnt_q    <= grace_cnt_d;
      phase_change_q <= (phase_d != phase_q);
    end
  end

  // Lamps decode straight from the phase register so they track it exactly.
  always_comb begin
    red_lamp    = 1'b0;
    yellow_lamp = 1'b0;
    green_lamp  = 1'b0;
    unique case (phase_q)
      LIGHT_GREEN:  green_lamp  = 1'b1;
      LIGHT_YELLOW: yellow_lamp = 1'b1;
      LIGHT_RED:    red_lamp    = 1'b1;
      default:      ;
    endcase
  end

  assign red_light    = (phase_q == LIGHT_RED) && (grace_cnt_q >= GRACE_LEN);
  assign phase        = phase_q;
  assign phase_change = phase_change_q;

endmodule

// File: doc/traffic_light.md
Name: traffic_light

Overview:
Generates the red/yellow/green light sequence for each round of Red Light, Green Light and drives the game controller's red_light input. It runs only while game_active is high. Green and red durations are randomised by an on-chip LFSR and shortened as rounds progress. red_light is asserted only after a grace window inside the red phase, so a player already moving when the lamp turns red is not disqualified instantly. The lamp outputs and phase pulse feed the VGA draw controller and the sound logic.

Parameters:
GREEN_MIN, 28'd75_000_000, minimum green duration in cycles (1.5 s at 50 MHz)
GREEN_STEP, 28'd6_250_000, green increment per unit of random value
YELLOW_LEN, 28'd25_000_000, fixed yellow duration in cycles
RED_MIN, 28'd50_000_000, minimum red duration in cycles
RED_STEP, 28'd6_250_000, red increment per unit of random value
ROUND_TRIM, 28'd12_500_000, green reduction per round beyond round 1
GRACE_LEN, 28'd5_000_000, cycles from red lamp on until red_light asserts
RAND_EN, 1'b1, 0 forces the random term to zero (deterministic durations)
LFSR_SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'h0001

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-low reset
game_active  in  1  high while the controller is in reset_positions or playing
round_num  in  2  current round, 1..3
red_light  out  1  enforced red, used for disqualification
red_lamp  out  1  red lamp for display
yellow_lamp  out  1  yellow lamp for display
green_lamp  out  1  green lamp for display
phase  out  2  current light_phase_t
phase_change  out  1  one-cycle pulse on every phase entry, including OFF

Behaviour:
- Reset (asynchronous, reset==0):
  - phase=LIGHT_OFF; all lamps, red_light and phase_change are 0.
  - phase_cnt=0, grace_cnt=0, lfsr=seed.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11 (mask 16'hB400).
  - Advances every cycle in all states, so durations depend on when the player presses start.
  - rnd = RAND_EN ? lfsr[3:0] : 0, sampled on the clock edge that enters a phase.
- Duration arithmetic: 28-bit unsigned, no wrap.
  - green_len = GREEN_MIN + rnd*GREEN_STEP - trim, where trim = (round_num-1)*ROUND_TRIM.
  - round_num 0 is treated as 1.
  - If the subtraction would drop below GREEN_MIN/2, green_len = GREEN_MIN/2.
  - red_len = RED_MIN + rnd*RED_STEP.
  - yellow_len = YELLOW_LEN.
- State machine (registered phase; lamps decoded from phase, so they change the same cycle phase changes):
  - OFF -> GREEN when game_active==1. phase_cnt loads green_len-1.
  - GREEN: phase_cnt decrements. At 0 -> YELLOW, phase_cnt loads YELLOW_LEN-1.
  - YELLOW: at 0 -> RED, phase_cnt loads red_len-1, grace_cnt loads 0.
  - RED: grace_cnt increments, saturating at GRACE_LEN. red_light = (phase==RED) && grace_cnt>=GRACE_LEN. At phase_cnt 0 -> GREEN with a fresh green_len.
  - Each phase therefore lasts exactly its length in cycles.
- game_active==0 in any non-OFF state: next edge -> OFF.
  - red_light falls on that edge.
  - Counters clear.
  - Takes priority over any pending phase transition.
- game_active re-asserted: sequence always restarts at GREEN; no resume of the old phase.
- GRACE_LEN >= red_len: red_light never asserts in that red phase. This is legal.
- Length parameters must be >= 1. A length of 1 gives a one-cycle phase.
- phase_change is high for the single cycle after any phase register update to a different value.

Decomposition:
- Package traffic_pkg:
  - light_phase_t enum {LIGHT_OFF=2'd0, LIGHT_GREEN=2'd1, LIGHT_YELLOW=2'd2, LIGHT_RED=2'd3}
  - DUR_W=28
  - LFSR_MASK=16'hB400
- Sub-module lfsr16:
  - Ports: clk, reset, seed, q[15:0].
  - Free-running; applies the zero-seed substitution.

Test Plan:
All cases use GREEN_MIN=8, GREEN_STEP=2, YELLOW_LEN=4, RED_MIN=6, RED_STEP=1, ROUND_TRIM=2, GRACE_LEN=2.
1. RAND_EN=0, round_num=1, game_active rises at cycle 0 -> expected lamps:
   - green cycles 1-8, yellow 9-12, red 13-18, green again at 19;
   - red_light high cycles 15-18;
   - phase_change pulses at 1, 9, 13, 19.
2. RAND_EN=0, round_num=3 -> green lasts 4 cycles (8-4=4, equal to the GREEN_MIN/2 floor). With ROUND_TRIM=3 -> still 4 cycles (clamped).
3. game_active drops mid-RED after red_light is high -> on the next edge phase=OFF, red_light=0, phase_change=1. Re-raising game_active restarts at GREEN for the full 8 cycles.
4. Assert reset low asynchronously mid-YELLOW, between clock edges -> all outputs 0 immediately. After release with game_active=1, green starts on the first edge.
5. RAND_EN=1, LFSR_SEED=16'hACE1, 20 full cycles -> each green/red length matches a reference model of the LFSR sampled at phase entry. Lengths lie within [8,38] and [6,21].
6. LFSR_SEED=0 -> lfsr equals 16'h0001 after reset and never reaches 0 over 65535 cycles. Period is 65535.
